// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
//
// This is the registered result and flag stage that sits after the 16-bit ALU.
// It captures each ALU result together with its opcode, destination index and
// carry/overflow/sign bits. Captured entries wait in a 2-entry skid buffer.
// The head entry drives the register-file writeback port. When an ADD or SUB
// commits, the stage also updates the architectural flags {Z, C, V, S} and a
// saturating overflow-event counter.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready upstream handshake; in_ready is a register output
//   in_opcode, in_rd  opcode and destination register of the ALU result
//   in_result         16-bit ALU result
//   in_carry, in_overflow, in_sign   ALU status bits
//   out_valid/out_ready   writeback handshake
//   wb_data, wb_rd, wb_we writeback payload; wb_we is low for NOP
//   flags_clr         synchronous clear of the flags register
//   flags             {Z, C, V, S}
//   ovf_count         saturating count of committed overflowing ADD/SUB
// ----------------------------------------------------------------------------
module alu_result_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [2:0]  in_rd,
    input  logic [15:0] in_result,
    input  logic        in_carry,
    input  logic        in_overflow,
    input  logic        in_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_rd,
    output logic        wb_we,
    input  logic        flags_clr,
    output logic [3:0]  flags,
    output logic [7:0]  ovf_count
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [2:0]  rd;
        logic [15:0] result;
        logic        z;
        logic        c;
        logic        v;
        logic        s;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t      r_state;
    entry_t      r_head;
    entry_t      r_skid;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [3:0]  r_flags;
    logic [7:0]  r_ovf_count;

    entry_t      w_in_entry;
    logic        w_accept;
    logic        w_commit;
    logic        w_head_addsub;

    // Z is computed once, at capture. This keeps the compare off the writeback path.
    always_comb begin
        w_in_entry.opcode = in_opcode;
        w_in_entry.rd     = in_rd;
        w_in_entry.result = in_result;
        w_in_entry.z      = (in_result == 16'h0000);
        w_in_entry.c      = in_carry;
        w_in_entry.v      = in_overflow;
        w_in_entry.s      = in_sign;
    end

    assign w_accept      = in_valid & r_in_ready;
    assign w_commit      = r_out_valid & out_ready;
    assign w_head_addsub = (r_head.opcode == OP_ADD) || (r_head.opcode == OP_SUB);

    // Buffer FSM. in_ready and out_valid are registered alongside the state.
    // They therefore always equal (state != TWO) and (state != EMPTY).
    // There is no combinational path from out_ready to in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_head      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_head      <= w_in_entry;
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && !w_commit) begin
                        // The consumer stalled, so the new entry is parked behind the head.
                        r_skid     <= w_in_entry;
                        r_state    <= S_TWO;
                        r_in_ready <= 1'b0;
                    end else if (!w_accept && w_commit) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_accept && w_commit) begin
                        r_head <= w_in_entry;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so the only event that can occur is a commit.
                    if (w_commit) begin
                        r_head     <= r_skid;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // An ADD/SUB commit takes priority over flags_clr in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_commit && w_head_addsub) begin
            r_flags <= {r_head.z, r_head.c, r_head.v, r_head.s};
        end else if (flags_clr) begin
            r_flags <= 4'b0000;
        end
    end

    // Counts overflowing ADD/SUB commits. It sticks at 8'hFF and is not affected by flags_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= 8'h00;
        end else if (w_commit && w_head_addsub && r_head.v && (r_ovf_count != 8'hFF)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign wb_data   = r_head.result;
    assign wb_rd     = r_head.rd;
    assign wb_we     = r_out_valid & (r_head.opcode != OP_NOP);
    assign flags     = r_flags;
    assign ovf_count = r_ovf_count;

endmodule
